digest_collector: RTL and testbench

Receive-side partner of the `Top` hash core's byte-serial output. It watches `o_valid`/`o_data` from `Top`, reassembles the NBYTES-byte digest into one parallel word, and offers that word downstream on a valid/ready handshake. It sits between `Top` and the host/result logic, and is the synthesizable counterpart of the byte-capture loop our `Top` benches use.

---
 rtl/digest_collector_if.sv | 27 ++
 rtl/digest_collector.sv | 123 ++++++++++++
 tb/tb_digest_collector.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/digest_collector_if.sv
// Bundles the byte-serial capture inputs and the parallel digest handshake outputs.
`default_nettype none

interface digest_collector_if #(
  parameter int NBYTES = 32
);
  logic [7:0]          i_data;
  logic                i_valid;
  logic                i_digest_ready;
  logic [8*NBYTES-1:0] o_digest;
  logic                o_digest_valid;
  logic                o_busy;
  logic                o_overrun;
  logic [7:0]          o_frame_cnt;

  modport master (
    output i_data, i_valid, i_digest_ready,
    input  o_digest, o_digest_valid, o_busy, o_overrun, o_frame_cnt
  );

  modport slave (
    input  i_data, i_valid, i_digest_ready,
    output o_digest, o_digest_valid, o_busy, o_overrun, o_frame_cnt
  );
endinterface

`default_nettype wire

// File: rtl/digest_collector.sv
// ============================================================================
// digest_collector
// Reassembles an NBYTES byte-serial digest into one word with valid/ready out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module digest_collector #(
  parameter int NBYTES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  digest_collector_if.slave bus
);
  localparam int            CW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CW-1:0]       count;
  logic                valid_q;
  logic                start;
  logic                handshake;
  logic                load_first;
  logic                store_cap;
  logic                busy;
  logic                digest_valid;
  logic                overrun;
  logic [7:0]          frame_cnt;
  logic [8*NBYTES-1:0] digest;

  // Only the rising edge of i_valid starts a frame; the held level is ignored.
  assign start = bus.i_valid & ~valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (count == LAST) state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.i_digest_ready) state_nxt = start ? CAPTURE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == CAPTURE);
    digest_valid = (state == HOLD);
    store_cap    = (state == CAPTURE);
    handshake    = (state == HOLD) && bus.i_digest_ready;
    // A start edge coinciding with the handshake begins the next frame at once.
    load_first   = start && ((state == IDLE) || handshake);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      count     <= '0;
      frame_cnt <= 8'd0;
      overrun   <= 1'b0;
    end else begin
      valid_q <= bus.i_valid;
      if (load_first) begin
        count <= CW'(1);
      end else if (store_cap) begin
        count <= count + CW'(1);
      end
      if (handshake) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if ((state == HOLD) && !bus.i_digest_ready && start) begin
        overrun <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NBYTES; k++) begin : g_byte
    logic [7:0] byte_q;
    logic       we;

    if (k == 0) begin : g_first
      assign we = load_first;
    end else begin : g_rest
      assign we = store_cap && (count == CW'(k));
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        byte_q <= 8'd0;
      end else if (we) begin
        byte_q <= bus.i_data;
      end
    end

    assign digest[8*k +: 8] = byte_q;
  end

  assign bus.o_digest       = digest;
  assign bus.o_digest_valid = digest_valid;
  assign bus.o_busy         = busy;
  assign bus.o_overrun      = overrun;
  assign bus.o_frame_cnt    = frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_digest_collector.sv
// Self-checking bench for digest_collector: vector table, corner sequences, random traffic vs a queue model.
`default_nettype none

module tb_digest_collector;
  localparam int NB = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  digest_collector_if #(.NBYTES(NB)) bus ();

  digest_collector #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bytes of the frame being captured, plus the held digest.
  logic [7:0]      mq[$];
  logic            m_held;
  logic [8*NB-1:0] m_digest;
  logic            m_over;
  logic [7:0]      m_cnt;
  logic            m_pv;

  typedef struct {
    logic [7:0]      base;
    logic [7:0]      inc;
    logic            held;
    int              idle;
    logic [8*NB-1:0] exp_digest;
    logic [7:0]      exp_cnt;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [8*NB-1:0] act, input logic [8*NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    logic e;
    if (!rst_n) begin
      mq.delete();
      m_held = 1'b0; m_digest = '0; m_over = 1'b0; m_cnt = 8'd0; m_pv = 1'b0;
    end else begin
      e = v & ~m_pv;
      if (mq.size() != 0) begin
        mq.push_back(d);
        if (mq.size() == NB) begin
          m_held = 1'b1;
          for (int k = 0; k < NB; k++) m_digest[8*k +: 8] = mq[k];
          mq.delete();
        end
      end else if (m_held) begin
        if (r) begin
          m_cnt  = m_cnt + 8'd1;
          m_held = 1'b0;
          if (e) mq.push_back(d);
        end else if (e) begin
          m_over = 1'b1;
        end
      end else if (e) begin
        mq.push_back(d);
      end
      m_pv = v;
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, compare 1 ns later.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    bus.i_valid = v; bus.i_data = d; bus.i_digest_ready = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
    chk("digest_valid", (8*NB)'(bus.o_digest_valid), (8*NB)'(m_held));
    chk("busy", (8*NB)'(bus.o_busy), (8*NB)'(mq.size() != 0));
    chk("overrun", (8*NB)'(bus.o_overrun), (8*NB)'(m_over));
    chk("frame_cnt", (8*NB)'(bus.o_frame_cnt), (8*NB)'(m_cnt));
    if (m_held) chk("digest", bus.o_digest, m_digest);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    chk("rst_digest", bus.o_digest, '0);
    chk("rst_flags", (8*NB)'({bus.o_digest_valid, bus.o_busy, bus.o_overrun}), '0);
    chk("rst_cnt", (8*NB)'(bus.o_frame_cnt), '0);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] inc, input logic held, input logic r0);
    cyc(1'b1, base, r0);
    for (int k = 1; k < NB; k++) cyc(held, base + 8'(k) * inc, 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h01, 1'b0, 10,
                256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100, 8'd1};
    vecs[1] = '{8'hA5, 8'h00, 1'b1, 6, {32{8'hA5}}, 8'd2};
    vecs[2] = '{8'h40, 8'h01, 1'b0, 3,
                256'h5F5E5D5C5B5A595857565554535251504F4E4D4C4B4A49484746454443424140, 8'd3};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 2,
                256'h9F9E9D9C9B9A999897969594939291908F8E8D8C8B8A89888786858483828180, 8'd4};

    bus.i_valid = 1'b0; bus.i_data = 8'h00; bus.i_digest_ready = 1'b0;
    mq.delete();
    m_held = 1'b0; m_digest = '0; m_over = 1'b0; m_cnt = 8'd0; m_pv = 1'b0;
    do_reset();
    cyc(1'b0, 8'h00, 1'b0);

    // Table: basic pulse frames and held-level frames, each followed by idle then handshake.
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].base, vecs[i].inc, vecs[i].held, 1'b0);
      for (int j = 0; j < vecs[i].idle; j++) cyc(vecs[i].held, 8'h5A, 1'b0);
      chk("vec_valid", (8*NB)'(bus.o_digest_valid), (8*NB)'(1));
      chk("vec_busy", (8*NB)'(bus.o_busy), '0);
      chk("vec_digest", bus.o_digest, vecs[i].exp_digest);
      cyc(vecs[i].held, 8'h5A, 1'b1);
      chk("vec_cnt", (8*NB)'(bus.o_frame_cnt), (8*NB)'(vecs[i].exp_cnt));
      chk("vec_drop", (8*NB)'(bus.o_digest_valid), '0);
      cyc(vecs[i].held, 8'h5A, 1'b0);
      chk("vec_no_recap", (8*NB)'(bus.o_busy), '0);
      cyc(1'b0, 8'h00, 1'b0);
    end

    // Overrun: frame B arrives while frame A is still held.
    do_reset();
    send_frame(8'h11, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    send_frame(8'h22, 8'h00, 1'b0, 1'b0);
    chk("ovr_flag", (8*NB)'(bus.o_overrun), (8*NB)'(1));
    chk("ovr_digest", bus.o_digest, {32{8'h11}});
    cyc(1'b0, 8'h00, 1'b1);
    chk("ovr_cnt", (8*NB)'(bus.o_frame_cnt), (8*NB)'(1));
    chk("ovr_idle", (8*NB)'({bus.o_busy, bus.o_digest_valid}), '0);

    // Start edge coinciding with the handshake.
    do_reset();
    send_frame(8'h00, 8'h01, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    send_frame(8'h40, 8'h01, 1'b0, 1'b1);
    chk("same_overrun", (8*NB)'(bus.o_overrun), '0);
    chk("same_digest", bus.o_digest,
        256'h5F5E5D5C5B5A595857565554535251504F4E4D4C4B4A49484746454443424140);
    cyc(1'b0, 8'h00, 1'b1);
    chk("same_cnt", (8*NB)'(bus.o_frame_cnt), (8*NB)'(2));

    // Reset in the middle of a capture, then a clean frame.
    do_reset();
    cyc(1'b1, 8'hEE, 1'b0);
    for (int k = 1; k < 15; k++) cyc(1'b0, 8'hEE, 1'b0);
    do_reset();
    send_frame(8'h80, 8'h01, 1'b0, 1'b0);
    chk("rmid_digest", bus.o_digest,
        256'h9F9E9D9C9B9A999897969594939291908F8E8D8C8B8A89888786858483828180);
    chk("rmid_cnt0", (8*NB)'(bus.o_frame_cnt), '0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("rmid_cnt1", (8*NB)'(bus.o_frame_cnt), (8*NB)'(1));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 3) == 0);

    // Counter wrap: 256 back-to-back frames with ready held high.
    do_reset();
    for (int f = 0; f < 256; f++) begin
      cyc(1'b1, 8'($urandom), 1'b1);
      if (f == 255) chk("wrap_255", (8*NB)'(bus.o_frame_cnt), (8*NB)'(255));
      for (int k = 1; k < NB; k++) cyc(1'b0, 8'($urandom), 1'b1);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("wrap_0", (8*NB)'(bus.o_frame_cnt), '0);
    chk("wrap_no_overrun", (8*NB)'(bus.o_overrun), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
